pkt_buf_cpu_seq: RTL and testbench

Sequencer that gives the host CPU ordered, multi-word access to the packet buffer inside the IDS drop FIFO while a packet is parked for CPU processing. It decodes a level-held software command register, requests the buffer from the datapath, runs single or burst reads/writes with auto-incrementing address, folds read data into an XOR signature, and issues the one-cycle packet-release pulse that returns the IDS pipeline to START. It sits between `generic_regs` and the drop FIFO's CPU port, inside `ids`.

---
 rtl/ids_cpu_pkg.sv | 45 ++++
 rtl/pkt_buf_cpu_seq.sv | 179 +++++++++++++++++
 tb/tb_pkt_buf_cpu_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ids_cpu_pkg.sv
// ============================================================================
// Module   : ids_cpu_pkg
// Purpose  : Shared command/status layout and sequencer states for CPU buffer access
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ids_cpu_pkg;

  // sw_cmd field positions
  localparam int CMD_REL     = 0;
  localparam int CMD_EN      = 4;
  localparam int CMD_WR      = 8;
  localparam int CMD_SEQ_LO  = 12;
  localparam int CMD_SEQ_HI  = 15;
  localparam int CMD_LEN_LO  = 16;
  localparam int CMD_LEN_HI  = 23;
  localparam int CMD_ADDR_LO = 24;
  localparam int CMD_ADDR_HI = 31;

  // status bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_SEQ_LO  = 4;
  localparam int STAT_SEQ_HI  = 7;
  localparam int STAT_ADDR_LO = 8;
  localparam int STAT_ADDR_HI = 15;
  localparam int STAT_REM_LO  = 16;
  localparam int STAT_REM_HI  = 23;

  localparam int BUF_W = 72;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_ACCESS  = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_buf_cpu_seq.sv
// ============================================================================
// Module   : pkt_buf_cpu_seq
// Purpose  : CPU command sequencer for burst access to the parked-packet buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_buf_cpu_seq
  import ids_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [31:0]                      sw_cmd,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] sw_wdata,
  input  logic                             pkt_parked,
  output logic                             mem_cpu_sel,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_wdata,
  output logic                             mem_we,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_rdata,
  output logic                             pkt_release,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] rd_data,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] rd_xor,
  output logic [31:0]                      status
);

  localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

  state_e                r_state;
  state_e                w_next;
  logic [3:0]            r_last_seq;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_remain;
  logic [1:0]            r_wcnt;
  logic                  r_write;
  logic                  r_rel;
  logic                  r_mem_sel;
  logic                  r_mem_we;
  logic [WORD_W-1:0]     r_mem_wdata;
  logic [WORD_W-1:0]     r_rd_data;
  logic [WORD_W-1:0]     r_rd_xor;

  logic                  w_new_cmd;
  logic                  w_last;
  logic                  w_wait_end;
  logic                  w_in_xfer;
  logic                  w_abort;
  logic                  w_step;
  logic                  w_capture;
  state_e                w_exit;
  logic [31:0]           w_status;
  logic                  w_unused;

  assign w_new_cmd  = (sw_cmd[CMD_SEQ_HI:CMD_SEQ_LO] != r_last_seq);
  assign w_last     = (r_remain == 8'd0);
  assign w_wait_end = (r_wcnt == 2'(RD_LAT - 1));
  assign w_in_xfer  = (r_state == S_GRANT) || (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign w_abort    = w_in_xfer && !pkt_parked;
  assign w_exit     = r_rel ? S_RELEASE : S_DONE;
  assign w_step     = pkt_parked && !w_last &&
                      (((r_state == S_ACCESS) && r_write) || ((r_state == S_WAIT) && w_wait_end));
  assign w_capture  = pkt_parked && (r_state == S_WAIT) && w_wait_end;
  assign w_unused   = ^{sw_cmd[3:1], sw_cmd[7:5], sw_cmd[11:9]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_new_cmd) begin
          if (sw_cmd[CMD_EN])       w_next = pkt_parked ? S_GRANT : S_DONE;
          else if (sw_cmd[CMD_REL]) w_next = S_RELEASE;
          else                      w_next = S_DONE;
        end
      end
      S_GRANT:  w_next = pkt_parked ? S_ACCESS : S_DONE;
      S_ACCESS: begin
        if (!pkt_parked)  w_next = S_DONE;
        else if (r_write) w_next = w_last ? w_exit : S_ACCESS;
        else              w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!pkt_parked)     w_next = S_DONE;
        else if (w_wait_end) w_next = w_last ? w_exit : S_ACCESS;
      end
      S_RELEASE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last_seq  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_wcnt      <= '0;
      r_write     <= 1'b0;
      r_rel       <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_rd_xor    <= '0;
    end else begin
      r_state <= w_next;

      if ((r_state == S_IDLE) && w_new_cmd) begin
        r_last_seq <= sw_cmd[CMD_SEQ_HI:CMD_SEQ_LO];
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= sw_cmd[CMD_EN] && !pkt_parked;
        r_addr     <= ADDR_WIDTH'(sw_cmd[CMD_ADDR_HI:CMD_ADDR_LO]);
        r_remain   <= sw_cmd[CMD_LEN_HI:CMD_LEN_LO];
        r_write    <= sw_cmd[CMD_WR];
        r_rel      <= sw_cmd[CMD_REL];
        if (sw_cmd[CMD_EN] && pkt_parked && !sw_cmd[CMD_WR]) r_rd_xor <= '0;
      end

      if (w_abort) r_error <= 1'b1;

      if (w_step) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - 8'd1;
      end

      if (w_capture) begin
        r_rd_data <= mem_rdata;
        r_rd_xor  <= r_rd_xor ^ mem_rdata;
      end

      if ((r_state == S_WAIT) && !w_wait_end) r_wcnt <= r_wcnt + 2'd1;
      else                                    r_wcnt <= '0;

      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end

      // Port controls are decoded from the next state so they line up with it
      r_mem_sel <= (w_next == S_GRANT) || (w_next == S_ACCESS) || (w_next == S_WAIT);
      r_mem_we  <= (w_next == S_ACCESS) && r_write;
      if ((w_next == S_ACCESS) && r_write) r_mem_wdata <= sw_wdata;
    end
  end

  always_comb begin
    w_status                              = '0;
    w_status[STAT_BUSY]                   = r_busy;
    w_status[STAT_DONE]                   = r_done;
    w_status[STAT_ERR]                    = r_error;
    w_status[STAT_SEQ_HI:STAT_SEQ_LO]     = r_last_seq;
    w_status[STAT_ADDR_HI:STAT_ADDR_LO]   = 8'(r_addr);
    w_status[STAT_REM_HI:STAT_REM_LO]     = r_remain;
  end

  assign mem_cpu_sel = r_mem_sel;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign pkt_release = (r_state == S_RELEASE);
  assign rd_data     = r_rd_data;
  assign rd_xor      = r_rd_xor;
  assign status      = w_status;

endmodule

`default_nettype wire

// File: tb/tb_pkt_buf_cpu_seq.sv
// ============================================================================
// Module   : tb_pkt_buf_cpu_seq
// Purpose  : Directed vector bench for pkt_buf_cpu_seq with a 1-cycle buffer model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_buf_cpu_seq;
  import ids_cpu_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      sw_cmd;
  logic [BUF_W-1:0] sw_wdata;
  logic             pkt_parked;
  logic             mem_cpu_sel;
  logic [7:0]       mem_addr;
  logic [BUF_W-1:0] mem_wdata;
  logic             mem_we;
  logic [BUF_W-1:0] mem_rdata;
  logic             pkt_release;
  logic [BUF_W-1:0] rd_data;
  logic [BUF_W-1:0] rd_xor;
  logic [31:0]      status;

  logic             ld_we;
  logic [7:0]       ld_addr;
  logic [BUF_W-1:0] ld_data;
  logic [BUF_W-1:0] mem [256];

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rel_cnt = 0;
  int sel_cnt = 0;
  int bad_we = 0;
  logic [7:0] wr_log [1024];

  always #5 clk = ~clk;

  pkt_buf_cpu_seq #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .RD_LAT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_cmd     (sw_cmd),
    .sw_wdata   (sw_wdata),
    .pkt_parked (pkt_parked),
    .mem_cpu_sel(mem_cpu_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .pkt_release(pkt_release),
    .rd_data    (rd_data),
    .rd_xor     (rd_xor),
    .status     (status)
  );

  // Buffer with one cycle of read latency plus a bench preload port
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (ld_we) mem[ld_addr]  <= ld_data;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wr_log[wr_cnt % 1024] <= mem_addr;
      wr_cnt <= wr_cnt + 1;
    end
    if (pkt_release)            rel_cnt <= rel_cnt + 1;
    if (mem_cpu_sel)            sel_cnt <= sel_cnt + 1;
    if (mem_we && !mem_cpu_sel) bad_we  <= bad_we + 1;
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) begin
      if (status[STAT_DONE] && !status[STAT_BUSY]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) chk({name, "_timeout"}, 72'(seen), 72'(1));
  endtask

  typedef struct {
    logic [31:0]      cmd;
    logic [BUF_W-1:0] wdata;
    logic             parked;
    logic [31:0]      st;
    logic [BUF_W-1:0] rd;
    logic [BUF_W-1:0] x;
    int               nwr;
    int               nrel;
    int               nsel;
    logic [7:0]       lwa;
  } vec_t;

  vec_t vt [7];

  initial begin : main
    int wr0, rel0, sel0, n0, k;
    logic [7:0] e_addr;

    vt[0] = '{32'h1003_1110, 72'hAB_0123_4567_89AB_CDEF, 1'b1, 32'h0000_1312,
              72'h0, 72'h0, 4, 0, 5, 8'h13};
    vt[1] = '{32'hFE02_2010, 72'h0, 1'b1, 32'h0000_0022,
              72'h04_0000_0000_0000_F000, 72'h07_0000_0000_0000_FFF0, 0, 0, 7, 8'h00};
    vt[2] = '{32'h4005_3010, 72'h0, 1'b0, 32'h0005_4036,
              72'h04_0000_0000_0000_F000, 72'h07_0000_0000_0000_FFF0, 0, 0, 0, 8'h00};
    vt[3] = '{32'h8000_4111, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 32'h0000_8042,
              72'h04_0000_0000_0000_F000, 72'h07_0000_0000_0000_FFF0, 1, 1, 2, 8'h80};
    vt[4] = '{32'h0000_5001, 72'h0, 1'b1, 32'h0000_0052,
              72'h04_0000_0000_0000_F000, 72'h07_0000_0000_0000_FFF0, 0, 1, 0, 8'h00};
    vt[5] = '{32'h0000_6000, 72'h0, 1'b1, 32'h0000_0062,
              72'h04_0000_0000_0000_F000, 72'h07_0000_0000_0000_FFF0, 0, 0, 0, 8'h00};
    vt[6] = '{32'h1000_7010, 72'h0, 1'b1, 32'h0000_1072,
              72'hAB_0123_4567_89AB_CDEF, 72'hAB_0123_4567_89AB_CDEF, 0, 0, 3, 8'h00};

    reset_n = 1'b0; sw_cmd = '0; sw_wdata = '0; pkt_parked = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", 72'({mem_cpu_sel, mem_we, pkt_release, mem_addr, status}), 72'h0);
    chk("reset_wdata", mem_wdata, 72'h0);
    chk("reset_rd_data", rd_data, 72'h0);
    chk("reset_rd_xor", rd_xor, 72'h0);

    ld_we = 1'b1; ld_addr = 8'hFE; ld_data = 72'h01_0000_0000_0000_00F0;
    @(negedge clk); ld_addr = 8'hFF; ld_data = 72'h02_0000_0000_0000_0F00;
    @(negedge clk); ld_addr = 8'h00; ld_data = 72'h04_0000_0000_0000_F000;
    @(negedge clk); ld_we = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      wr0 = wr_cnt; rel0 = rel_cnt; sel0 = sel_cnt;
      @(negedge clk);
      sw_cmd = vt[i].cmd; sw_wdata = vt[i].wdata; pkt_parked = vt[i].parked;
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_status", i), 72'(status), 72'(vt[i].st));
      chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].rd);
      chk($sformatf("v%0d_rd_xor", i), rd_xor, vt[i].x);
      chk($sformatf("v%0d_writes", i), 72'(wr_cnt - wr0), 72'(vt[i].nwr));
      chk($sformatf("v%0d_releases", i), 72'(rel_cnt - rel0), 72'(vt[i].nrel));
      chk($sformatf("v%0d_sel_cycles", i), 72'(sel_cnt - sel0), 72'(vt[i].nsel));
      if (vt[i].nwr != 0) begin
        k = (wr_cnt - 1) % 1024;
        chk($sformatf("v%0d_last_waddr", i), 72'(wr_log[k]), 72'(vt[i].lwa));
      end
    end

    // Cycle-accurate write burst: 4 words at 0x20 in cycles 2..5
    @(negedge clk);
    sw_cmd = 32'h2003_8110; sw_wdata = 72'h5A_A5A5_A5A5_A5A5_A5A5; pkt_parked = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      e_addr = 8'(32 + ((c < 2) ? 0 : (c > 5) ? 3 : c - 2));
      chk($sformatf("t_c%0d_ctl", c), 72'({mem_cpu_sel, mem_we, mem_addr}),
          72'({(c <= 5) ? 1'b1 : 1'b0, (c >= 2 && c <= 5) ? 1'b1 : 1'b0, e_addr}));
      if (c >= 2 && c <= 5) chk($sformatf("t_c%0d_wdata", c), mem_wdata, 72'h5A_A5A5_A5A5_A5A5_A5A5);
    end
    wait_done("t");

    // Release-only: pulse in cycle 1, DONE in cycle 2, done flag in cycle 3
    @(negedge clk);
    sw_cmd = 32'h0000_9001;
    @(posedge clk); #1;
    chk("rel_c1_pulse", 72'(pkt_release), 72'(1));
    @(posedge clk); #1;
    chk("rel_c2_state", 72'({pkt_release, status[1:0]}), 72'(3'b001));
    @(posedge clk); #1;
    chk("rel_c3_state", 72'({pkt_release, status[1:0]}), 72'(3'b010));
    wait_done("rel");

    // Parked packet withdrawn in the third word of an 8-word burst
    wr0 = wr_cnt; rel0 = rel_cnt;
    @(negedge clk);
    sw_cmd = 32'h3007_A111; sw_wdata = 72'h33_3333_3333_3333_3333;
    repeat (4) @(posedge clk);
    @(negedge clk); pkt_parked = 1'b0;
    @(posedge clk); #1;
    chk("abort_port_off", 72'({mem_cpu_sel, mem_we}), 72'h0);
    wait_done("abort");
    chk("abort_status", 72'(status), 72'h0005_32A6);
    chk("abort_writes", 72'(wr_cnt - wr0), 72'(3));
    chk("abort_no_release", 72'(rel_cnt - rel0), 72'(0));
    @(negedge clk); pkt_parked = 1'b1;

    // Reset during a burst, then the level-held command replays from its start
    @(negedge clk);
    sw_cmd = 32'h5007_3110; sw_wdata = 72'h77_0000_0000_0000_0077;
    repeat (4) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 72'({mem_cpu_sel, mem_we, pkt_release, mem_addr, status}), 72'h0);
    chk("rst_mid_rd", rd_data | rd_xor | mem_wdata, 72'h0);
    n0 = wr_cnt;
    @(negedge clk); reset_n = 1'b1;
    wait_done("replay");
    chk("replay_first_addr", 72'(wr_log[n0 % 1024]), 72'h50);
    chk("replay_writes", 72'(wr_cnt - n0), 72'(8));
    chk("replay_status", 72'(status), 72'h0000_5732);

    chk("we_without_sel", 72'(bad_we), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
